// File: rtl/lva_pkg.sv
// lva_pkg: shared types and default widths for the local variable array arbiter
package lva_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    typedef enum logic [1:0] {IDLE, CHECK, WAIT, RESP} state_t;
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] index;
        logic [DATA_W-1:0] wdata;
    } req_t;
endpackage

// File: rtl/lva_req_latch.sv
// lva_req_latch: per-port request register with pending/busy flag
module lva_req_latch
    import lva_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              trigger,
    input  logic              write,
    input  logic [ADDR_W-1:0] index,
    input  logic [DATA_W-1:0] wdata,
    input  logic              clear,
    output logic              busy,
    output logic              req_write,
    output logic [ADDR_W-1:0] req_index,
    output logic [DATA_W-1:0] req_wdata
);
    req_t q;
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            q    <= '0;
        end else if (clear) begin
            busy <= 1'b0;
        end else if (trigger && !busy) begin
            busy <= 1'b1;
            q    <= '{write: write, index: index, wdata: wdata};
        end
    end
    assign req_write = q.write;
    assign req_index = q.index;
    assign req_wdata = q.wdata;
endmodule

// File: rtl/lva_arbiter.sv
// lva_arbiter: round-robin access to the local variable array with frame checks and timeout
module lva_arbiter #(
    parameter int ADDR_W  = lva_pkg::ADDR_W,
    parameter int DATA_W  = lva_pkg::DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] frame_base,
    input  logic [ADDR_W-1:0] frame_size,
    input  logic              req0_trigger,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_index,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_busy,
    output logic              req0_done,
    output logic              req0_err,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_trigger,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_index,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_busy,
    output logic              req1_done,
    output logic              req1_err,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              mem_trigger,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done
);
    import lva_pkg::*;
    localparam int CW = $clog2(TIMEOUT + 1);
    state_t            state;
    logic              grant, last_grant, next_grant, err_q, upd;
    logic [ADDR_W-1:0] base_q, size_q;
    logic [DATA_W-1:0] rd_buf;
    logic [CW-1:0]     cnt;
    req_t              r0, r1, cur;
    lva_req_latch u_latch0 (
        .clk(clk), .rst(rst), .trigger(req0_trigger), .write(req0_write), .index(req0_index),
        .wdata(req0_wdata), .clear(state == RESP && !grant), .busy(req0_busy),
        .req_write(r0.write), .req_index(r0.index), .req_wdata(r0.wdata)
    );
    lva_req_latch u_latch1 (
        .clk(clk), .rst(rst), .trigger(req1_trigger), .write(req1_write), .index(req1_index),
        .wdata(req1_wdata), .clear(state == RESP && grant), .busy(req1_busy),
        .req_write(r1.write), .req_index(r1.index), .req_wdata(r1.wdata)
    );
    assign cur        = grant ? r1 : r0;
    assign next_grant = (req0_busy && req1_busy) ? !last_grant : req1_busy;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            {grant, err_q, upd, base_q, size_q, rd_buf, cnt} <= '0;
            last_grant  <= 1'b1;
            {mem_trigger, mem_write, mem_addr, mem_wdata} <= '0;
            {req0_done, req0_err, req0_rdata, req1_done, req1_err, req1_rdata} <= '0;
        end else begin
            mem_trigger <= 1'b0;
            {req0_done, req0_err, req1_done, req1_err} <= '0;
            case (state)
                IDLE: if (req0_busy || req1_busy) begin
                    grant      <= next_grant;
                    last_grant <= next_grant;
                    base_q     <= frame_base;
                    size_q     <= frame_size;
                    state      <= CHECK;
                end
                CHECK: begin
                    upd <= 1'b0;
                    if (cur.index >= size_q) begin
                        err_q <= 1'b1;
                        state <= RESP;
                    end else begin
                        mem_addr    <= base_q - size_q + cur.index;
                        mem_write   <= cur.write;
                        mem_wdata   <= cur.wdata;
                        mem_trigger <= 1'b1;
                        err_q       <= 1'b0;
                        cnt         <= '0;
                        state       <= WAIT;
                    end
                end
                WAIT: if (mem_done) begin
                    rd_buf <= mem_rdata;
                    upd    <= !mem_write;
                    state  <= RESP;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    err_q <= 1'b1;
                    state <= RESP;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                RESP: begin
                    if (grant) begin
                        req1_done <= 1'b1;
                        req1_err  <= err_q;
                        if (upd) req1_rdata <= rd_buf;
                    end else begin
                        req0_done <= 1'b1;
                        req0_err  <= err_q;
                        if (upd) req0_rdata <= rd_buf;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lva_arbiter.sv
// tb_lva_arbiter: directed and randomized checks of lva_arbiter against a frame/memory model
module tb_lva_arbiter;
    logic        clk = 0, rst = 1;
    logic [7:0]  frame_base = 0, frame_size = 0;
    logic        trig [2];
    logic        wr [2];
    logic [7:0]  index [2];
    logic [31:0] wdata [2];
    logic        busy [2];
    logic        done [2];
    logic        err [2];
    logic [31:0] rdata [2];
    logic        mem_trigger, mem_write, mem_done;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata = 0;
    logic        resp_done = 0, inj_done = 0, withhold = 0;
    int          lat_max = 1, hold = 0, checks = 0, failures = 0;
    logic [7:0]  raddr = 0;
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic [31:0] prev [2];

    assign mem_done = resp_done | inj_done;
    always #5 clk = ~clk;

    lva_arbiter dut (
        .clk(clk), .rst(rst), .frame_base(frame_base), .frame_size(frame_size),
        .req0_trigger(trig[0]), .req0_write(wr[0]), .req0_index(index[0]), .req0_wdata(wdata[0]),
        .req0_busy(busy[0]), .req0_done(done[0]), .req0_err(err[0]), .req0_rdata(rdata[0]),
        .req1_trigger(trig[1]), .req1_write(wr[1]), .req1_index(index[1]), .req1_wdata(wdata[1]),
        .req1_busy(busy[1]), .req1_done(done[1]), .req1_err(err[1]), .req1_rdata(rdata[1]),
        .mem_trigger(mem_trigger), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done)
    );

    // arrayblock model: acts on the trigger, answers after a random latency
    always @(negedge clk) begin
        resp_done = 0;
        if (hold > 0) begin
            hold = hold - 1;
            if (hold == 0) begin
                resp_done = 1;
                mem_rdata = mem[raddr];
            end
        end
        if (mem_trigger && !withhold && !rst) begin
            raddr = mem_addr;
            if (mem_write) mem[mem_addr] = mem_wdata;
            hold = $urandom_range(1, lat_max);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        prev[0] = 0;
        prev[1] = 0;
    endtask

    task automatic do_req(input int p, input bit w, input logic [7:0] idx, input logic [31:0] wd,
                          input logic [7:0] base, input logic [7:0] size, input int exp_cyc);
        logic [7:0] a;
        bit e, seen;
        int cyc, ntrig;
        a = base - size + idx;
        e = (idx >= size) || withhold;
        @(negedge clk);
        frame_base = base; frame_size = size;
        wr[p] = w; index[p] = idx; wdata[p] = wd; trig[p] = 1;
        @(negedge clk);
        trig[p] = 0;
        chk("busy_set", 32'(busy[p]), 1);
        cyc = 1; seen = 0; ntrig = 0;
        while (!seen && cyc < 80) begin
            if (mem_trigger) begin
                ntrig++;
                chk("mem_addr", 32'(mem_addr), 32'(a));
                chk("mem_write", 32'(mem_write), 32'(w));
                if (w) chk("mem_wdata", mem_wdata, wd);
            end
            if (done[p]) seen = 1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("done_seen", 32'(seen), 1);
        chk("err", 32'(err[p]), 32'(e));
        chk("busy_clr", 32'(busy[p]), 0);
        chk("mem_trig_count", ntrig, (idx < size) ? 1 : 0);
        if (exp_cyc > 0) chk("latency", cyc, exp_cyc);
        if (!e && w) ref_mem[a] = wd;
        if (!e && !w) prev[p] = ref_mem[a];
        chk("rdata", rdata[p], prev[p]);
    endtask

    task automatic both_writes(input logic [7:0] i0, input logic [7:0] i1, input logic [31:0] d0, input logic [31:0] d1);
        int order[$];
        int ntrig, cyc;
        bit inflight, ovl;
        @(negedge clk);
        frame_base = 8'd40; frame_size = 8'd16;
        wr[0] = 1; index[0] = i0; wdata[0] = d0; trig[0] = 1;
        wr[1] = 1; index[1] = i1; wdata[1] = d1; trig[1] = 1;
        @(negedge clk);
        trig[0] = 0; trig[1] = 0;
        ntrig = 0; cyc = 0; inflight = 0; ovl = 0;
        while (order.size() < 2 && cyc < 100) begin
            if (mem_trigger) begin
                if (inflight) ovl = 1;
                inflight = 1;
                ntrig++;
            end
            if (done[0]) begin order.push_back(0); inflight = 0; end
            if (done[1]) begin order.push_back(1); inflight = 0; end
            @(negedge clk);
            cyc++;
        end
        chk("rr_count", order.size(), 2);
        if (order.size() == 2) begin
            chk("rr_first", order[0], 0);
            chk("rr_second", order[1], 1);
        end
        chk("rr_triggers", ntrig, 2);
        chk("rr_overlap", 32'(ovl), 0);
        ref_mem[8'(8'd24 + i0)] = d0;
        ref_mem[8'(8'd24 + i1)] = d1;
    endtask

    initial begin
        int seen;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0001;
            ref_mem[i] = mem[i];
        end
        for (int p = 0; p < 2; p++) begin
            trig[p] = 0; wr[p] = 0; index[p] = 0; wdata[p] = 0; prev[p] = 0;
        end
        do_reset();
        chk("rst_flags", {24'd0, mem_trigger, mem_write, done[0], done[1], err[0], err[1], busy[0], busy[1]}, 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rdata0", rdata[0], 0);
        chk("rst_rdata1", rdata[1], 0);

        // single read with fixed latency; base 8 - size 3 + 1 = 6
        mem[6] = 32'hDEAD_BEEF; ref_mem[6] = 32'hDEAD_BEEF;
        do_req(0, 0, 8'd1, 0, 8'd8, 8'd3, 6);
        chk("t1_rdata", rdata[0], 32'hDEAD_BEEF);

        // simultaneous writes alternate starting with port 0
        do_reset();
        both_writes(8'd2, 8'd3, 32'hAAAA_0001, 32'hBBBB_0001);
        both_writes(8'd4, 8'd5, 32'hAAAA_0002, 32'hBBBB_0002);
        do_req(0, 0, 8'd3, 0, 8'd40, 8'd16, 0);
        do_req(1, 0, 8'd4, 0, 8'd40, 8'd16, 0);

        // out-of-frame keeps previous rdata
        do_req(1, 0, 8'd2, 0, 8'd2, 8'd2, 0);
        chk("t3_rdata_kept", rdata[1], 32'hAAAA_0002);

        // address wrap is legal
        do_req(0, 0, 8'd0, 0, 8'd1, 8'd4, 0);
        chk("t4_rdata", rdata[0], mem[8'hFD]);
        do_req(1, 0, 8'd0, 0, 8'd9, 8'd0, 0);

        // watchdog: 15 WAIT cycles then error
        withhold = 1;
        do_req(0, 0, 8'd1, 0, 8'd20, 8'd5, 19);
        @(negedge clk); inj_done = 1;
        @(negedge clk); inj_done = 0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done[0] || done[1] || mem_trigger) seen++;
        end
        chk("late_done_ignored", seen, 0);
        withhold = 0;
        do_req(0, 0, 8'd2, 0, 8'd20, 8'd5, 0);

        // reset while in WAIT
        withhold = 1;
        @(negedge clk);
        frame_base = 8'd50; frame_size = 8'd4;
        wr[1] = 1; index[1] = 8'd1; wdata[1] = 32'h1234_5678; trig[1] = 1;
        @(negedge clk); trig[1] = 0;
        repeat (4) @(negedge clk);
        chk("pre_rst_addr", 32'(mem_addr), 32'd47);
        rst = 1;
        @(negedge clk);
        chk("mid_rst_flags", {24'd0, mem_trigger, mem_write, done[0], done[1], err[0], err[1], busy[0], busy[1]}, 0);
        chk("mid_rst_addr", 32'(mem_addr), 0);
        chk("mid_rst_wdata", mem_wdata, 0);
        rst = 0; prev[0] = 0; prev[1] = 0;
        @(negedge clk); inj_done = 1;
        @(negedge clk); inj_done = 0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done[0] || done[1] || mem_trigger || busy[0] || busy[1]) seen++;
        end
        chk("post_rst_quiet", seen, 0);
        withhold = 0;

        // randomized traffic against the frame/memory model
        lat_max = 4;
        for (int n = 0; n < 40; n++) begin
            int p;
            bit w;
            logic [7:0] base, size, idx;
            p = $urandom_range(0, 1);
            w = 1'($urandom_range(0, 1));
            base = 8'($urandom);
            size = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            if ($urandom_range(0, 3) == 0) idx = size + 8'($urandom_range(0, 2));
            else idx = (size == 0) ? 8'd0 : 8'($urandom % size);
            do_req(p, w, idx, $urandom, base, size, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lva_arbiter.md
Name: lva_arbiter

Overview:
Shares the single-port local variable array (256 x 32 arrayblock) between two requesters and translates method-local indices into absolute LVA addresses.
- Port 0: control unit (load/store bytecodes).
- Port 1: invoke sequencer (argument moves from eval stack into a new frame).
- Sits between the requesters and the arrayblock trigger/done interface, with round-robin grant, frame bounds checking and a memory timeout watchdog.

Parameters:
ADDR_W, 8, LVA address and index width
DATA_W, 32, LVA word width
TIMEOUT, 15, max cycles in WAIT before an access is aborted

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
frame_base  in  ADDR_W  current LVA offset (top of current frame), sampled at grant
frame_size  in  ADDR_W  local-variable count of current frame, sampled at grant
reqN_trigger  in  1  (N=0,1) one-cycle request pulse
reqN_write  in  1  1 = write, 0 = read; sampled with trigger
reqN_index  in  ADDR_W  method-local index; sampled with trigger
reqN_wdata  in  DATA_W  write data; sampled with trigger
reqN_busy  out  1  request pending or in service
reqN_done  out  1  one-cycle completion pulse
reqN_err  out  1  valid with done: out-of-frame or timeout
reqN_rdata  out  DATA_W  read result; valid with done, held until next done on that port
mem_trigger  out  1  one-cycle pulse to arrayblock
mem_write  out  1  arrayblock write select
mem_addr  out  ADDR_W  absolute LVA address
mem_wdata  out  DATA_W  arrayblock write data
mem_rdata  in  DATA_W  arrayblock read data
mem_done  in  1  arrayblock one-cycle done pulse

Behaviour:
Reset: all outputs 0, pending bits clear, state IDLE, last_grant=1 (port 0 wins first tie), timeout counter 0.

Request capture:
- A trigger with busy=0 latches write/index/wdata and sets pending; busy goes high the next cycle.
- A trigger with busy=1 is ignored.
- busy falls in the same cycle as done, so a trigger in the done cycle is accepted.

State machine (registered outputs):
- IDLE: if any pending, grant per round-robin. A single pending port is granted directly. If both are pending, grant the port != last_grant. Update last_grant, sample frame_base/frame_size -> CHECK.
- CHECK:
  - If index >= frame_size: go to RESP with err=1, rdata unchanged, no memory access.
  - Otherwise drive mem_addr = frame_base - frame_size + index (mod 2^ADDR_W) plus mem_write/mem_wdata, pulse mem_trigger for one cycle, clear counter -> WAIT.
- WAIT: mem_addr/mem_write/mem_wdata held stable.
  - On mem_done: capture mem_rdata (reads only; writes leave rdata unchanged) -> RESP with err=0.
  - If the counter reaches TIMEOUT without mem_done: RESP with err=1.
- RESP: one-cycle done (and err) on the granted port, clear its pending bit -> IDLE.

Latency: trigger at cycle 0 -> mem_trigger at cycle 3 -> done one cycle after RESP entry, i.e. 2 cycles after mem_done.

Boundaries:
- mem_done outside WAIT is ignored.
- frame_size=0 rejects every index.
- Address wrap-around is intended: no error is raised for base < size.
- Round-robin guarantees that port N waits at most one access of the other port.

Reset mid-operation: returns to IDLE, clears pending and outputs, aborts any in-flight access without done. A late mem_done is ignored.

Decomposition:
- Shared package lva_pkg:
  - state enum (IDLE, CHECK, WAIT, RESP)
  - ADDR_W/DATA_W defaults
  - request struct {write, index, wdata}
- One sub-module, lva_req_latch, instanced per port: pending bit, request register and busy logic.
- Arbitration FSM, address arithmetic and watchdog stay in the top module.

Test Plan:
1. Port 0 read, frame_base=8, frame_size=3, index=1 -> mem_addr=6, mem_write=0. Memory returns 0xDEADBEEF one cycle after trigger -> req0_rdata=0xDEADBEEF, req0_done pulse, req0_err=0.
2. After reset, both ports trigger writes in the same cycle, then repeat -> grant order 0,1,0,1. Exactly one mem_trigger per access, never overlapping.
3. frame_size=2, index=2 on port 1 -> req1_done with req1_err=1, no mem_trigger. req1_rdata keeps its previous value.
4. frame_base=1, frame_size=4, index=0 -> mem_addr=0xFD, err=0 (wrap accepted).
5. mem_done withheld -> err=1 done after 15 WAIT cycles. A subsequent port-0 request is served normally; a mem_done arriving late is ignored.
6. rst asserted in WAIT -> all outputs 0 and busy=0 next cycle, no done. A mem_done pulse after reset produces no response.
